// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pkg
// Description : Shared types and helpers for the vector strided load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam logic [2:0] C_VSEW_E8  = 3'b000;
    localparam logic [2:0] C_VSEW_E16 = 3'b001;
    localparam logic [2:0] C_VSEW_E32 = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        misaligned;
    } st_lane_t;

    // Zero marks an illegal SEW encoding.
    function automatic logic [2:0] sew_bytes(input logic [2:0] vsew);
        case (vsew)
            C_VSEW_E8:  sew_bytes = 3'd1;
            C_VSEW_E16: sew_bytes = 3'd2;
            C_VSEW_E32: sew_bytes = 3'd4;
            default:    sew_bytes = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_strided_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_strided_lsu_if
// Description : Word-wide coprocessor memory port (valid/ready request bus).
// Revision    : 1.0 - initial release
// ============================================================================
interface vec_strided_lsu_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vec_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : vec_lane_align
// Description : Maps one SEW element onto / off the 32-bit memory word lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_lane_align
    import vec_pkg::*;
(
    input  wire logic [2:0]  vsew,
    input  wire logic [1:0]  byte_off,
    input  wire logic [31:0] st_elem,
    input  wire logic [31:0] rdata,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             misaligned,
    output logic [31:0]      ld_elem
);

    function automatic st_lane_t store_lane(input logic [2:0]  sew,
                                            input logic [1:0]  a,
                                            input logic [31:0] e);
        st_lane_t r;
        r = '0;
        r.misaligned = 1'b1;
        case (sew)
            C_VSEW_E8: begin
                r.wdata      = {4{e[7:0]}};
                r.wstrb      = 4'b0001 << a;
                r.misaligned = 1'b0;
            end
            C_VSEW_E16: begin
                r.wdata      = {2{e[15:0]}};
                r.wstrb      = 4'b0011 << a;
                r.misaligned = a[0];
            end
            C_VSEW_E32: begin
                r.wdata      = e;
                r.wstrb      = 4'b1111;
                r.misaligned = (a != 2'b00);
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_lane(input logic [2:0]  sew,
                                              input logic [1:0]  a,
                                              input logic [31:0] d);
        logic [31:0] w;
        w = d >> {a, 3'b000};
        case (sew)
            C_VSEW_E8:  load_lane = {24'h0, w[7:0]};
            C_VSEW_E16: load_lane = {16'h0, w[15:0]};
            default:    load_lane = w;
        endcase
    endfunction

    st_lane_t w_st;

    assign w_st       = store_lane(vsew, byte_off, st_elem);
    assign wdata      = w_st.wdata;
    assign wstrb      = w_st.wstrb;
    assign misaligned = w_st.misaligned;
    assign ld_elem    = load_lane(vsew, byte_off, rdata);

endmodule
`default_nettype wire

// File: rtl/vec_strided_lsu.sv
`default_nettype none
// ============================================================================
// Module      : vec_strided_lsu
// Description : Strided vector load/store initiator, one word access per element.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_strided_lsu
    import vec_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    input  wire logic            cmd_valid,
    output logic                 cmd_ready,
    input  wire logic            cmd_store,
    input  wire logic [31:0]     cmd_base,
    input  wire logic [31:0]     cmd_stride,
    input  wire logic [31:0]     cmd_vl,
    input  wire logic [2:0]      cmd_vsew,
    input  wire logic [VLEN-1:0] vdata_in,
    output logic [VLEN-1:0]      vdata_out,
    output logic                 done,
    output logic                 err,
    vec_strided_lsu_if.master    mem
);

    localparam int IDXW = $clog2(VLEN / 8) + 1;
    localparam int SHW  = $clog2(VLEN);

    lsu_state_e      r_state;
    lsu_state_e      w_state_nxt;
    logic            r_store;
    logic [2:0]      r_vsew;
    logic [31:0]     r_addr;
    logic [31:0]     r_stride;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] r_n;
    logic [VLEN-1:0] r_vbuf;
    logic            r_err;

    logic [IDXW-1:0] w_vlmax;
    logic [IDXW-1:0] w_n;
    logic            w_sew_legal;
    logic [SHW-1:0]  w_shift;
    logic [31:0]     w_sew_mask;
    logic [31:0]     w_st_elem;
    logic [31:0]     w_ld_elem;
    logic [31:0]     w_wdata;
    logic [3:0]      w_wstrb;
    logic            w_mis;
    logic            w_hs;
    logic            w_last;
    logic [IDXW-1:0] w_idx_nxt;
    logic [VLEN-1:0] w_vbuf_ld;

    // Element count clamped to VLMAX of the requested SEW.
    always_comb begin
        w_vlmax = '0;
        case (cmd_vsew)
            C_VSEW_E8:  w_vlmax = IDXW'(VLEN / 8);
            C_VSEW_E16: w_vlmax = IDXW'(VLEN / 16);
            C_VSEW_E32: w_vlmax = IDXW'(VLEN / 32);
            default:    ;
        endcase
        w_n = (cmd_vl > 32'(w_vlmax)) ? w_vlmax : cmd_vl[IDXW-1:0];
    end

    assign w_sew_legal = (sew_bytes(cmd_vsew) != 3'd0);

    always_comb begin
        w_shift    = '0;
        w_sew_mask = '0;
        case (r_vsew)
            C_VSEW_E8: begin
                w_shift    = SHW'({r_idx, 3'b000});
                w_sew_mask = 32'h0000_00ff;
            end
            C_VSEW_E16: begin
                w_shift    = SHW'({r_idx, 4'b0000});
                w_sew_mask = 32'h0000_ffff;
            end
            C_VSEW_E32: begin
                w_shift    = SHW'({r_idx, 5'b00000});
                w_sew_mask = 32'hffff_ffff;
            end
            default: ;
        endcase
    end

    assign w_st_elem = 32'(r_vbuf >> w_shift);
    assign w_vbuf_ld = (r_vbuf & ~(VLEN'(w_sew_mask) << w_shift))
                     | (VLEN'(w_ld_elem) << w_shift);

    vec_lane_align u_lane (
        .vsew       (r_vsew),
        .byte_off   (r_addr[1:0]),
        .st_elem    (w_st_elem),
        .rdata      (mem.mem_rdata),
        .wdata      (w_wdata),
        .wstrb      (w_wstrb),
        .misaligned (w_mis),
        .ld_elem    (w_ld_elem)
    );

    assign w_hs      = mem.mem_valid && mem.mem_ready;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (w_idx_nxt == r_n);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = (!w_sew_legal || (w_n == '0)) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_mis || (w_hs && w_last)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_store  <= 1'b0;
            r_vsew   <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
            r_n      <= '0;
            r_vbuf   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_store  <= cmd_store;
                        r_vsew   <= cmd_vsew;
                        r_addr   <= cmd_base;
                        r_stride <= cmd_stride;
                        r_idx    <= '0;
                        r_n      <= w_n;
                        r_vbuf   <= vdata_in;
                        r_err    <= !w_sew_legal;
                    end
                end
                S_REQ: begin
                    if (w_mis) begin
                        r_err <= 1'b1;
                    end else if (w_hs) begin
                        if (!r_store) begin
                            r_vbuf <= w_vbuf_ld;
                        end
                        r_idx  <= w_idx_nxt;
                        r_addr <= r_addr + r_stride;
                    end
                end
                default: ;
            endcase
        end
    end

    // The request is combinational on state so reset drops it immediately.
    assign cmd_ready     = (r_state == S_IDLE);
    assign mem.mem_valid = (r_state == S_REQ) && !w_mis;
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata = ((r_state == S_REQ) && r_store) ? w_wdata : 32'h0;
    assign mem.mem_wstrb = (mem.mem_valid && r_store) ? w_wstrb : 4'b0000;
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign vdata_out     = r_vbuf;

endmodule
`default_nettype wire

// File: doc/vec_strided_lsu.md
# vec_strided_lsu

- Memory-side initiator for vector strided loads (`vlse.v`) and stores (`vsse.v`) inside `picorv32_pcpi_vec`.
- Takes one command: base, byte stride, `vl`, SEW and direction. It then issues one word-wide transaction per element on the coprocessor memory port (`mem_valid`/`mem_ready`) and assembles or scatters a full vector register.
- Sits between the vector decode FSM and the system memory responder.

## Interface

Parameters:
- `VLEN`, 128: vector register width in bits; VLMAX = VLEN/SEW.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_store` in 1: 1 = store, 0 = load.
- `cmd_base` in 32: byte address of element 0.
- `cmd_stride` in 32: signed byte stride.
- `cmd_vl` in 32: element count, clamped to VLMAX.
- `cmd_vsew` in 3: 000 = 8, 001 = 16, 010 = 32; others are illegal.
- `vdata_in` in VLEN: store data, or old vd for a load. Sampled at command accept.
- `vdata_out` out VLEN: load result, including the undisturbed tail. Valid while `done` is high.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; misaligned element or illegal SEW.
- `mem_valid` out 1: request is held until `mem_ready`.
- `mem_ready` in 1: responder completion.
- `mem_addr` out 32: word-aligned (`addr & ~3`).
- `mem_wdata` out 32: store lanes.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_rdata` in 32: valid in the cycle `mem_ready` is high.

## Operation

States:
- IDLE: `cmd_ready` = 1.
  - A `cmd_valid` edge latches the command and loads `vbuf` ← `vdata_in`, `addr` ← `cmd_base`, `idx` ← 0, `n` ← min(`cmd_vl`, VLMAX).
  - Goes to DONE if `n` = 0 or SEW is illegal (`err` = 1 when SEW is illegal). Otherwise goes to REQ.
- REQ: checks the current element's alignment before asserting `mem_valid`.
  - Misaligned means SEW16 with `addr[0]` = 1, or SEW32 with `addr[1:0]` ≠ 0.
  - Misaligned: `mem_valid` stays 0, set `err`, go to DONE.
  - Aligned: drive `mem_valid` = 1, `mem_addr` = {`addr[31:2]`, 2'b00} and strobes.
  - On an edge with `mem_valid && mem_ready`:
    - Load: extract `mem_rdata >> 8*addr[1:0]` (SEW bits) into `vbuf` element `idx`.
    - Then `idx++` and `addr += stride` (mod 2^32, so wrap-around is legal).
    - Go to DONE when `idx` = `n`-1, else stay in REQ.
- DONE: `done` = 1 for one cycle, `vdata_out` = `vbuf`, then IDLE. `err` is cleared on the next accept.

Lane rules:
- Store: `mem_wdata` = element replicated across the word.
- `mem_wstrb` is 0001 << `a` for SEW8, 0011 << `a` for SEW16 and 1111 for SEW32, where `a` = `addr[1:0]`.
- Elements `idx` ≥ `n` are untouched: tail undisturbed for loads, not written for stores.
- Stride 0 is legal: the same address is accessed `n` times.

## Timing

- Reset: all state returns to IDLE. `cmd_ready` = 1. `mem_valid`, `mem_wstrb`, `done` and `err` = 0. `mem_addr`, `mem_wdata` and `vdata_out` = 0.
- `mem_valid` rises the cycle after accept. Address, data and strobe are stable while `mem_valid` is high and unacknowledged.
- The responder registers `mem_ready` one cycle after seeing valid and ignores valid while `ready` is high. With that responder each element costs 2 cycles, and accept→`done` = 2·`n`+1 cycles.
- The next element's request is presented in the cycle right after the ready edge; there is no idle bubble.
- `vl` = 0: `done` is high the cycle after accept, with no memory traffic.
- `cmd_valid` while busy is ignored (`cmd_ready` = 0).
- Reset mid-transaction: `mem_valid` drops asynchronously, the command is discarded and no `done` is produced.

## Structure

- Package `vec_pkg`:
  - VSEW encodings.
  - LSU state enum (IDLE/REQ/DONE).
  - A `sew_bytes()` function.
- Sub-module `vec_lane_align` (combinational), with two functions:
  - Store: (vsew, `addr[1:0]`, element) → `wdata`, `wstrb`, misaligned.
  - Load: (vsew, `addr[1:0]`, `rdata`) → element.

## Test plan

- Load SEW8, base 400, stride 1, `vl` 4, memory word 400 = 0x02010201. Required: `vdata_out[31:0]` = 0x02010201; upper bytes equal `vdata_in`; 4 transactions at addr 400; `done` at 9 cycles; `err` = 0.
- Load SEW32, base 440, stride 4, `vl` 3, words 0x0a, 0x14, 0x1e. Required: elements 0..2 = 0x0a, 0x14, 0x1e; `mem_addr` sequence 440, 444, 448.
- Store SEW8, base 800, stride 1, `vl` 4, `vdata_in` bytes AA BB CC DD. Required: `wstrb` 0001, 0010, 0100, 1000, all at addr 800; memory word 800 = 0xDDCCBBAA.
- Store SEW16, base 808, stride −2, `vl` 2, elements 0x1111 and 0x2222. Required: access at 808 with `wstrb` 0011, then at 804 with `wstrb` 1100 (byte address 806).
- Boundaries:
  - `vl` 0 → `done` 1 cycle after accept with no `mem_valid`.
  - SEW32 base 402 → `err` = 1 with `done`, and `mem_valid` never asserted.
  - `cmd_vl` 40 with SEW8 → 16 transactions.
- Reset mid-op: assert `resetn` = 0 during the 3rd element of a `vl` 8 load. Required: `mem_valid` = 0 immediately, IDLE after release, and a following command completes normally.
